// File: rtl/axis_result_buffer.sv
// axis_result_buffer: elastic AXI4-Stream buffer between the mm2s result drain and
// the DMA S2MM/host port. A DEPTH-entry synchronous FIFO feeds a registered output
// stage, with frame-done pulses, sticky overflow and an optional frame-length check.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   s_axis_*                 upstream beats; tready is registered almost-full back-pressure
//   m_axis_*                 downstream beats from the output register
//   expected_beats           beats per frame, latched on each frame's first beat
//   frame_done               one-cycle pulse, the cycle after a tlast handshake on m_axis
//   err_ovf / err_len        sticky error flags (cleared only by rst)
//   level                    FIFO occupancy, not counting the output register
//
// Optional feature macro: RESULT_BUF_LENCHECK_EN enables the per-frame beat-count check.
// With it undefined, err_len is tied low and expected_beats is ignored.
module axis_result_buffer #(
  parameter int D_W          = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_MARGIN = 3,
  parameter int BEAT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [D_W-1:0]      s_axis_tdata,
  input  logic [D_W/8-1:0]    s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [D_W-1:0]      m_axis_tdata,
  output logic [D_W/8-1:0]    m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [BEAT_W-1:0]   expected_beats,
  output logic                frame_done,
  output logic                err_ovf,
  output logic                err_len,
  output logic [ADDR_W:0]     level
);

  localparam int K_W    = D_W / 8;
  localparam int WORD_W = D_W + K_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  // Highest occupancy at which upstream may still be told "ready".
  localparam logic [ADDR_W:0] RDY_THR  = (ADDR_W+1)'(DEPTH - AFULL_MARGIN - 1);

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              s_rdy_q, s_rdy_d;
  logic              out_vld_q, out_vld_d;
  logic [D_W-1:0]    out_dat_q, out_dat_d;
  logic [K_W-1:0]    out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_ovf_q, err_ovf_d;

  logic              push;
  logic              pop;
  logic              out_load;
  logic [WORD_W-1:0] head_word;

  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_vld_d    = out_vld_q;
    out_dat_d    = out_dat_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;

    // Push ignores s_axis_tready: upstream may still send a few beats after
    // ready drops, and the reserved margin absorbs them.
    push     = s_axis_tvalid && (count_q != FULL_CNT);
    // The output register takes a new beat when empty or being drained.
    out_load = !out_vld_q || m_axis_tready;
    pop      = out_load && (count_q != '0);

    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    s_rdy_d = (count_d <= RDY_THR);

    if (pop) begin
      out_vld_d = 1'b1;
      {out_dat_d, out_keep_d, out_last_d} = head_word;
    end else if (out_load) begin
      out_vld_d = 1'b0;
    end

    frame_done_d = out_vld_q && m_axis_tready && out_last_q;
    err_ovf_d    = err_ovf_q || (s_axis_tvalid && (count_q == FULL_CNT));
  end

  // Storage array carries no reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      s_rdy_q      <= 1'b0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      s_rdy_q      <= s_rdy_d;
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

`ifdef RESULT_BUF_LENCHECK_EN
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] exp_beats_q, exp_beats_d;
  logic [BEAT_W-1:0] ordinal;
  logic [BEAT_W-1:0] target;
  logic              err_len_q, err_len_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    err_len_d   = err_len_q;
    ordinal     = beat_cnt_q + BEAT_W'(1);
    // On a frame's first beat the latch is not loaded yet, so use the live input.
    target      = (beat_cnt_q == '0) ? expected_beats : exp_beats_q;
    if (push) begin
      if (beat_cnt_q == '0) exp_beats_d = expected_beats;
      if (s_axis_tlast ? (ordinal != target) : (ordinal == target)) err_len_d = 1'b1;
      beat_cnt_d = s_axis_tlast ? '0 : ordinal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      err_len_q   <= err_len_d;
    end
  end

  assign err_len = err_len_q;
`else
  logic unused_expected_beats;
  assign unused_expected_beats = ^expected_beats;
  assign err_len = 1'b0;
`endif

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_dat_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign frame_done    = frame_done_q;
  assign err_ovf       = err_ovf_q;
  assign level         = count_q;

endmodule
